rom_readback_checker: RTL and testbench

- Self-checking read-out engine that sits directly upstream and downstream of the inferred dual-port ROM.
- Drives addr_a/addr_b and consumes q_a/q_b.
- Runs a full linear sweep of the address space, followed by a pseudo-random LFSR phase.
- Checks port-A/port-B consistency, compresses all read data into a 32-bit MISR signature, and reports pass/fail.
- Used on fabric as a bitstream-level built-in ROM test, so no per-address expected data file is needed.

---
 rtl/rom_readback_checker_if.sv | 13 +
 rtl/rom_readback_checker.sv | 163 ++++++++++++++++
 tb/tb_rom_readback_checker.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_readback_checker_if.sv
// rtl/rom_readback_checker_if.sv - dual-port ROM read bus between the checker and the ROM
interface rom_readback_checker_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 12
);
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [DATA_W-1:0] q_a;
    logic [DATA_W-1:0] q_b;

    modport master (output addr_a, output addr_b, input q_a, input q_b);
    modport slave  (input addr_a, input addr_b, output q_a, output q_b);
endinterface

// File: rtl/rom_readback_checker.sv
// rtl/rom_readback_checker.sv - ROM built-in self test: linear sweep then LFSR reads, A/B compare, MISR signature
module rom_readback_checker #(
    parameter int          ADDR_W       = 10,
    parameter int          DATA_W       = 12,
    parameter int          READ_LAT     = 1,
    parameter int          RAND_COUNT   = 2048,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          CNT_W        = 16,
    parameter int          CHECK_SIG    = 0,
    parameter logic [31:0] EXPECTED_SIG = 32'h0
) (
    input  logic                   clock0,
    input  logic                   reset,
    input  logic                   start,
    rom_readback_checker_if.master rom,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [CNT_W-1:0]       mismatch_count,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [31:0]            signature
);
    localparam int          TAG_W     = 2 * ADDR_W + 2;
    localparam int          RC_W      = $clog2(RAND_COUNT + 1);
    localparam logic [31:0] MISR_POLY = 32'h04C11DB7;

    typedef enum logic [2:0] {IDLE, SWEEP, RANDOM, DRAIN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] sweep_idx;
    logic [RC_W-1:0]   rand_cnt;
    logic [2:0]        drain_cnt;
    logic [15:0]       lfsr;
    logic              issue_valid;
    logic [31:0]       misr;
    logic [TAG_W-1:0]  tag_pipe [READ_LAT];

    logic [15:0]       lfsr_next;
    logic [TAG_W-1:0]  ret_tag;
    logic              ret_valid;
    logic              ret_same;
    logic [ADDR_W-1:0] ret_addr_a;
    logic [ADDR_W-1:0] ret_addr_b;
    logic [31:0]       ret_data;
    logic [31:0]       misr_next;
    logic              tag_unused;

    // Fibonacci LFSR, taps x^16+x^14+x^13+x^11+1, shifting toward the MSB
    assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};

    // Oldest tag lines up with the data currently on q_a/q_b
    assign ret_tag    = tag_pipe[READ_LAT-1];
    assign ret_valid  = ret_tag[TAG_W-1];
    assign ret_addr_a = ret_tag[TAG_W-2 -: ADDR_W];
    assign ret_addr_b = ret_tag[ADDR_W:1];
    assign ret_same   = ret_tag[0];
    assign tag_unused = ^ret_addr_b;

    assign ret_data  = 32'({rom.q_a, rom.q_b});
    assign misr_next = {misr[30:0], 1'b0} ^ (misr[31] ? MISR_POLY : 32'h0) ^ ret_data;

    assign pass = done && (mismatch_count == '0) &&
                  ((CHECK_SIG == 0) || (signature == EXPECTED_SIG));

    always_ff @(posedge clock0) begin
        if (reset) begin
            state          <= IDLE;
            sweep_idx      <= '0;
            rand_cnt       <= '0;
            drain_cnt      <= '0;
            lfsr           <= LFSR_SEED;
            misr           <= 32'hFFFF_FFFF;
            issue_valid    <= 1'b0;
            rom.addr_a     <= '0;
            rom.addr_b     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            mismatch_count <= '0;
            fail_addr      <= '0;
            signature      <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= {issue_valid, rom.addr_a, rom.addr_b, (rom.addr_a == rom.addr_b)};
            for (int i = 1; i < READ_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
            signature <= misr;

            if (ret_valid) begin
                misr <= misr_next;
                // Case inequality so an X from the ROM is never silently accepted
                if (ret_same && (rom.q_a !== rom.q_b)) begin
                    if (mismatch_count == '0) begin
                        fail_addr <= ret_addr_a;
                    end
                    if (mismatch_count != '1) begin
                        mismatch_count <= mismatch_count + CNT_W'(1);
                    end
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= SWEEP;
                        sweep_idx      <= '0;
                        rand_cnt       <= '0;
                        drain_cnt      <= '0;
                        lfsr           <= LFSR_SEED;
                        misr           <= 32'hFFFF_FFFF;
                        issue_valid    <= 1'b1;
                        rom.addr_a     <= '0;
                        rom.addr_b     <= '0;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        mismatch_count <= '0;
                        fail_addr      <= '0;
                    end
                end
                SWEEP: begin
                    if (sweep_idx == '1) begin
                        state      <= RANDOM;
                        rom.addr_a <= lfsr[ADDR_W-1:0];
                        rom.addr_b <= lfsr[15 -: ADDR_W];
                        lfsr       <= lfsr_next;
                        rand_cnt   <= RC_W'(1);
                    end else begin
                        sweep_idx  <= sweep_idx + ADDR_W'(1);
                        rom.addr_a <= sweep_idx + ADDR_W'(1);
                        rom.addr_b <= sweep_idx + ADDR_W'(1);
                    end
                end
                RANDOM: begin
                    if (rand_cnt == RC_W'(RAND_COUNT)) begin
                        state       <= DRAIN;
                        issue_valid <= 1'b0;
                        rom.addr_a  <= '0;
                        rom.addr_b  <= '0;
                        drain_cnt   <= '0;
                    end else begin
                        rom.addr_a <= lfsr[ADDR_W-1:0];
                        rom.addr_b <= lfsr[15 -: ADDR_W];
                        lfsr       <= lfsr_next;
                        rand_cnt   <= rand_cnt + RC_W'(1);
                    end
                end
                DRAIN: begin
                    // One extra cycle beyond READ_LAT lets the last MISR update reach signature
                    if (drain_cnt == 3'(READ_LAT)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rom_readback_checker.sv
// tb/tb_rom_readback_checker.sv - directed bench for rom_readback_checker across several parameter sets
module tb_rom_readback_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start;
    logic fault37;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   t0 = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] rom_fn(input int a);
        return 12'(a) ^ 12'h5A5;
    endfunction

    // Reference sweep/LFSR/MISR; what: 0 signature, 1 raw mismatch count, 2 first fail address
    function automatic logic [31:0] model(input int aw, input int rc, input bit f37, input bit invb, input int what);
        logic [31:0] sig;
        logic [31:0] res;
        logic [15:0] l;
        logic [11:0] qa;
        logic [11:0] qb;
        int cnt;
        int faddr;
        int aa;
        int ab;
        sig = 32'hFFFF_FFFF;
        l = 16'hACE1;
        cnt = 0;
        faddr = 0;
        for (int i = 0; i < (1 << aw) + rc; i++) begin
            if (i < (1 << aw)) begin
                aa = i;
                ab = i;
            end else begin
                aa = int'(l) & ((1 << aw) - 1);
                ab = int'(l) >> (16 - aw);
                l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
            end
            qa = rom_fn(aa);
            qb = rom_fn(ab);
            if (f37 && ab == 37) qb = 12'h000;
            if (invb) qb = ~qb;
            sig = {sig[30:0], 1'b0} ^ (sig[31] ? 32'h04C11DB7 : 32'h0) ^ {8'h00, qa, qb};
            if (aa == ab && qa != qb) begin
                if (cnt == 0) faddr = aa;
                cnt = cnt + 1;
            end
        end
        if (what == 0) res = sig;
        else if (what == 1) res = 32'(cnt);
        else res = 32'(faddr);
        return res;
    endfunction

    localparam logic [31:0] GOLD_D = model(4, 16, 1'b0, 1'b0, 0);

    rom_readback_checker_if #(.ADDR_W(10), .DATA_W(12)) bus_a ();
    rom_readback_checker_if #(.ADDR_W(10), .DATA_W(12)) bus_b ();
    rom_readback_checker_if #(.ADDR_W(4),  .DATA_W(12)) bus_c ();
    rom_readback_checker_if #(.ADDR_W(4),  .DATA_W(12)) bus_d ();
    rom_readback_checker_if #(.ADDR_W(4),  .DATA_W(12)) bus_e ();

    logic busy_a, done_a, pass_a, busy_b, done_b, pass_b, busy_c, done_c, pass_c;
    logic busy_d, done_d, pass_d, busy_e, done_e, pass_e;
    logic [15:0] cnt_a, cnt_b, cnt_d, cnt_e;
    logic [1:0]  cnt_c;
    logic [9:0]  fa_a, fa_b;
    logic [3:0]  fa_c, fa_d, fa_e;
    logic [31:0] sig_a, sig_b, sig_c, sig_d, sig_e;

    rom_readback_checker u_a (.clock0(clk), .reset(reset), .start(start), .rom(bus_a.master),
        .busy(busy_a), .done(done_a), .pass(pass_a), .mismatch_count(cnt_a), .fail_addr(fa_a), .signature(sig_a));
    rom_readback_checker #(.READ_LAT(3)) u_b (.clock0(clk), .reset(reset), .start(start), .rom(bus_b.master),
        .busy(busy_b), .done(done_b), .pass(pass_b), .mismatch_count(cnt_b), .fail_addr(fa_b), .signature(sig_b));
    rom_readback_checker #(.ADDR_W(4), .CNT_W(2), .RAND_COUNT(64)) u_c (.clock0(clk), .reset(reset), .start(start),
        .rom(bus_c.master), .busy(busy_c), .done(done_c), .pass(pass_c), .mismatch_count(cnt_c), .fail_addr(fa_c),
        .signature(sig_c));
    rom_readback_checker #(.ADDR_W(4), .RAND_COUNT(16), .CHECK_SIG(1), .EXPECTED_SIG(GOLD_D)) u_d (.clock0(clk),
        .reset(reset), .start(start), .rom(bus_d.master), .busy(busy_d), .done(done_d), .pass(pass_d),
        .mismatch_count(cnt_d), .fail_addr(fa_d), .signature(sig_d));
    rom_readback_checker #(.ADDR_W(4), .RAND_COUNT(16), .CHECK_SIG(1), .EXPECTED_SIG(GOLD_D ^ 32'h1)) u_e (.clock0(clk),
        .reset(reset), .start(start), .rom(bus_e.master), .busy(busy_e), .done(done_e), .pass(pass_e),
        .mismatch_count(cnt_e), .fail_addr(fa_e), .signature(sig_e));

    logic [11:0] b_qa [2];
    logic [11:0] b_qb [2];

    always @(posedge clk) begin
        bus_a.q_a <= rom_fn(int'(bus_a.addr_a));
        bus_a.q_b <= (fault37 && bus_a.addr_b == 10'd37) ? 12'h000 : rom_fn(int'(bus_a.addr_b));
        b_qa[0]   <= rom_fn(int'(bus_b.addr_a));
        b_qb[0]   <= rom_fn(int'(bus_b.addr_b));
        b_qa[1]   <= b_qa[0];
        b_qb[1]   <= b_qb[0];
        bus_b.q_a <= b_qa[1];
        bus_b.q_b <= b_qb[1];
        bus_c.q_a <= rom_fn(int'(bus_c.addr_a));
        bus_c.q_b <= ~rom_fn(int'(bus_c.addr_b));
        bus_d.q_a <= rom_fn(int'(bus_d.addr_a));
        bus_d.q_b <= rom_fn(int'(bus_d.addr_b));
        bus_e.q_a <= rom_fn(int'(bus_e.addr_a));
        bus_e.q_b <= rom_fn(int'(bus_e.addr_b));
    end

    logic [4:0] done_v;
    logic [4:0] done_q = 5'b0;
    int         rise_cyc [5];
    assign done_v = {done_e, done_d, done_c, done_b, done_a};

    always @(negedge clk) begin
        for (int k = 0; k < 5; k++) begin
            if (done_v[k] === 1'b1 && done_q[k] !== 1'b1) rise_cyc[k] = cyc;
        end
        done_q = done_v;
    end

    logic [31:0] sig_ideal, sig_fault, sig_c_exp;
    int          cnt_fault, fa_fault;

    task automatic start_run();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; t0 = cyc;
    endtask

    task automatic wait_all(input string name);
        int n = 0;
        while (done_v !== 5'h1f && n < 6000) begin @(negedge clk); n++; end
        #1;
        vectors++; if (done_v !== 5'h1f) begin miscompares++; $display("FAIL %s_timeout: done=%b want 11111", name, done_v); end
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        vectors++; if (busy_a !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy_a); end
        vectors++; if (done_a !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done_a); end
        vectors++; if (pass_a !== 1'b0) begin miscompares++; $display("FAIL reset_pass: got %b want 0", pass_a); end
        vectors++; if (cnt_a !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
        vectors++; if (sig_a !== 32'd0) begin miscompares++; $display("FAIL reset_sig: got %h want 0", sig_a); end
        vectors++; if (bus_a.addr_a !== 10'd0 || bus_a.addr_b !== 10'd0) begin miscompares++;
            $display("FAIL reset_addr: got %0d/%0d want 0/0", bus_a.addr_a, bus_a.addr_b); end
        reset = 1'b0;
    endtask

    task automatic test_ideal();
        start_run();
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL ideal_busy_start: got %b want 1", busy_a); end
        vectors++; if (pass_a !== 1'b0) begin miscompares++; $display("FAIL ideal_pass_gated: got %b want 0", pass_a); end
        wait_all("ideal");
        vectors++; if (rise_cyc[0] - t0 !== 3074) begin miscompares++; $display("FAIL ideal_done_edge: got %0d want 3074", rise_cyc[0] - t0); end
        vectors++; if (cnt_a !== 16'd0) begin miscompares++; $display("FAIL ideal_count: got %0d want 0", cnt_a); end
        vectors++; if (pass_a !== 1'b1) begin miscompares++; $display("FAIL ideal_pass: got %b want 1", pass_a); end
        vectors++; if (sig_a !== sig_ideal) begin miscompares++; $display("FAIL ideal_sig: got %h want %h", sig_a, sig_ideal); end
        vectors++; if (busy_a !== 1'b0 || bus_a.addr_a !== 10'd0) begin miscompares++;
            $display("FAIL ideal_idle_outputs: busy %b addr %0d want 0 0", busy_a, bus_a.addr_a); end
    endtask

    task automatic test_fault37();
        fault37 = 1'b1;
        start_run();
        wait_all("fault37");
        vectors++; if (int'(cnt_a) !== cnt_fault) begin miscompares++; $display("FAIL fault37_count: got %0d want %0d", cnt_a, cnt_fault); end
        vectors++; if (fa_a !== 10'd37) begin miscompares++; $display("FAIL fault37_fail_addr: got %0d want 37", fa_a); end
        vectors++; if (pass_a !== 1'b0) begin miscompares++; $display("FAIL fault37_pass: got %b want 0", pass_a); end
        vectors++; if (sig_a !== sig_fault) begin miscompares++; $display("FAIL fault37_sig: got %h want %h", sig_a, sig_fault); end
        fault37 = 1'b0;
    endtask

    task automatic test_latency3();
        start_run();
        wait_all("lat3");
        vectors++; if (rise_cyc[1] - t0 !== 3076) begin miscompares++; $display("FAIL lat3_done_edge: got %0d want 3076", rise_cyc[1] - t0); end
        vectors++; if (rise_cyc[1] - rise_cyc[0] !== 2) begin miscompares++; $display("FAIL lat3_delta: got %0d want 2", rise_cyc[1] - rise_cyc[0]); end
        vectors++; if (cnt_b !== 16'd0 || fa_b !== 10'd0) begin miscompares++; $display("FAIL lat3_count: got %0d/%0d want 0/0", cnt_b, fa_b); end
        vectors++; if (sig_b !== sig_ideal) begin miscompares++; $display("FAIL lat3_sig: got %h want %h", sig_b, sig_ideal); end
        vectors++; if (pass_b !== 1'b1 || busy_b !== 1'b0) begin miscompares++; $display("FAIL lat3_pass: got %b busy %b want 1 0", pass_b, busy_b); end
    endtask

    task automatic test_saturate();
        start_run();
        wait_all("sat");
        vectors++; if (rise_cyc[2] - t0 !== 82) begin miscompares++; $display("FAIL sat_done_edge: got %0d want 82", rise_cyc[2] - t0); end
        vectors++; if (cnt_c !== 2'd3) begin miscompares++; $display("FAIL sat_count: got %0d want 3", cnt_c); end
        vectors++; if (fa_c !== 4'd0) begin miscompares++; $display("FAIL sat_fail_addr: got %0d want 0", fa_c); end
        vectors++; if (pass_c !== 1'b0 || busy_c !== 1'b0) begin miscompares++; $display("FAIL sat_pass: got %b busy %b want 0 0", pass_c, busy_c); end
        vectors++; if (sig_c !== sig_c_exp) begin miscompares++; $display("FAIL sat_sig: got %h want %h", sig_c, sig_c_exp); end
    endtask

    task automatic test_checksig();
        start_run();
        wait_all("checksig");
        vectors++; if (rise_cyc[3] - t0 !== 34) begin miscompares++; $display("FAIL checksig_done_edge: got %0d want 34", rise_cyc[3] - t0); end
        vectors++; if (sig_d !== GOLD_D) begin miscompares++; $display("FAIL checksig_sig: got %h want %h", sig_d, GOLD_D); end
        vectors++; if (pass_d !== 1'b1 || busy_d !== 1'b0) begin miscompares++; $display("FAIL checksig_pass_match: got %b busy %b want 1 0", pass_d, busy_d); end
        vectors++; if (pass_e !== 1'b0) begin miscompares++; $display("FAIL checksig_pass_flip: got %b want 0", pass_e); end
        vectors++; if (cnt_e !== 16'd0 || fa_e !== 4'd0 || cnt_d !== 16'd0 || fa_d !== 4'd0) begin miscompares++;
            $display("FAIL checksig_counts: got %0d/%0d %0d/%0d want zeros", cnt_d, fa_d, cnt_e, fa_e); end
        vectors++; if (busy_e !== 1'b0 || sig_e !== GOLD_D) begin miscompares++; $display("FAIL checksig_e_sig: got %h busy %b want %h 0", sig_e, busy_e, GOLD_D); end
    endtask

    task automatic test_reset_midrun();
        int n = 0;
        start_run();
        while (bus_a.addr_a !== 10'd500 && n < 2000) begin @(negedge clk); n++; end
        vectors++; if (bus_a.addr_a !== 10'd500) begin miscompares++; $display("FAIL midreset_reach500: got %0d want 500", bus_a.addr_a); end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++; if ({busy_a, done_a, pass_a} !== 3'b000) begin miscompares++; $display("FAIL midreset_flags: got %b want 000", {busy_a, done_a, pass_a}); end
        vectors++; if (cnt_a !== 16'd0 || fa_a !== 10'd0 || sig_a !== 32'd0) begin miscompares++;
            $display("FAIL midreset_regs: got %0d %0d %h want 0 0 0", cnt_a, fa_a, sig_a); end
        vectors++; if (bus_a.addr_a !== 10'd0 || bus_a.addr_b !== 10'd0) begin miscompares++;
            $display("FAIL midreset_addr: got %0d/%0d want 0/0", bus_a.addr_a, bus_a.addr_b); end
        start_run();
        wait_all("rerun");
        vectors++; if (rise_cyc[0] - t0 !== 3074) begin miscompares++; $display("FAIL rerun_done_edge: got %0d want 3074", rise_cyc[0] - t0); end
        vectors++; if (sig_a !== sig_ideal || cnt_a !== 16'd0 || pass_a !== 1'b1) begin miscompares++;
            $display("FAIL rerun_result: got %h %0d %b want %h 0 1", sig_a, cnt_a, pass_a, sig_ideal); end
    endtask

    task automatic test_start_midrandom();
        int t_orig;
        fault37 = 1'b1;
        start_run();
        t_orig = t0;
        repeat (1200) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        vectors++; if (busy_a !== 1'b1) begin miscompares++; $display("FAIL midstart_busy: got %b want 1", busy_a); end
        wait_all("midstart");
        vectors++; if (rise_cyc[0] - t_orig !== 3074) begin miscompares++; $display("FAIL midstart_done_edge: got %0d want 3074", rise_cyc[0] - t_orig); end
        vectors++; if (int'(cnt_a) !== cnt_fault) begin miscompares++; $display("FAIL midstart_count: got %0d want %0d", cnt_a, cnt_fault); end
        vectors++; if (int'(fa_a) !== fa_fault) begin miscompares++; $display("FAIL midstart_fail_addr: got %0d want %0d", fa_a, fa_fault); end
        vectors++; if (sig_a !== sig_fault) begin miscompares++; $display("FAIL midstart_sig: got %h want %h", sig_a, sig_fault); end
        fault37 = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        fault37 = 1'b0;
        sig_ideal = model(10, 2048, 1'b0, 1'b0, 0);
        sig_fault = model(10, 2048, 1'b1, 1'b0, 0);
        cnt_fault = int'(model(10, 2048, 1'b1, 1'b0, 1));
        if (cnt_fault > 65535) cnt_fault = 65535;
        fa_fault  = int'(model(10, 2048, 1'b1, 1'b0, 2));
        sig_c_exp = model(4, 64, 1'b0, 1'b1, 0);
        test_reset();
        test_ideal();
        test_fault37();
        test_latency3();
        test_saturate();
        test_checksig();
        test_reset_midrun();
        test_start_midrandom();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
